alu_operand_ctrl: RTL

- Execute-stage operand scheduler for the 5-stage RISC-V pipeline.
- Tracks the destination info of in-flight instructions (EX, MEM, WB) internally.
- Generates the registered ALU input-2 select (register / immediate / constant 1) and the forwarding selects for both ALU operands.
- Detects load-use hazards and sequences a one-cycle decode stall with bubble insertion. Also honours branch flush and global hold.

---
 rtl/alu_ctrl_pkg.sv | 64 ++++++
 rtl/alu_operand_ctrl_fwd_compare.sv | 23 ++
 rtl/alu_operand_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types for the execute-stage operand scheduler: forward/source
// select encodings, the per-stage destination record and the stall FSM state.
package alu_ctrl_pkg;

    // Width of the rd field held in each stage record.
    localparam int RD_W = 5;

    // Stage positions inside the in-flight record array.
    localparam int EX_IDX     = 0;
    localparam int MEM_IDX    = 1;
    localparam int WB_IDX     = 2;
    localparam int NUM_STAGES = 3;

    // Number of stages that can feed a forwarding path (EX and MEM).
    localparam int NUM_FWD_STAGES = 2;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        SRC2_REG = 2'b00,
        SRC2_IMM = 2'b01,
        SRC2_ONE = 2'b10
    } src2_sel_t;

    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic            regWrite;
        logic            memRead;
    } stage_rec_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } ctrl_state_t;

    // An empty pipeline slot: nothing valid, nothing written.
    localparam stage_rec_t BUBBLE_REC = '0;

    // Map the raw ID request onto a legal mux select; the reserved code
    // falls back to the register operand so the mux never sees 11.
    function automatic src2_sel_t legal_src2(input logic [1:0] req);
        case (req)
            2'b01:   return SRC2_IMM;
            2'b10:   return SRC2_ONE;
            default: return SRC2_REG;
        endcase
    endfunction

    // The youngest producer wins: an EX match shadows an older MEM match.
    function automatic fwd_sel_t pick_fwd(input logic ex_hit, input logic mem_hit);
        if (ex_hit) begin
            return FWD_EXMEM;
        end else if (mem_hit) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/alu_operand_ctrl_fwd_compare.sv
// Combinational source-vs-producer match: true when the stage record will
// write the register the decode instruction wants to read. x0 never matches.
module fwd_compare
    import alu_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  rec_valid,
    input  logic [RD_W-1:0]       rec_rd,
    input  logic                  rec_reg_write,
    output logic                  hit
);

    logic [RD_W-1:0] rs_ext;

    // Bring the source index to record width, then qualify the equality.
    always_comb begin
        rs_ext = RD_W'(rs);
        hit    = rec_valid && rec_reg_write && (rec_rd != '0) && (rec_rd == rs_ext);
    end

endmodule

// File: rtl/alu_operand_ctrl.sv
// Execute-stage operand scheduler: tracks EX/MEM/WB destination records,
// registers the ALU input-2 and forwarding selects into EX, and sequences a
// single-cycle decode stall on load-use hazards. Hold freezes everything;
// a branch flush turns the incoming EX slot into a bubble.
module alu_operand_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  idValid,
    input  logic [REG_ADDR_W-1:0] idRs1,
    input  logic [REG_ADDR_W-1:0] idRs2,
    input  logic [REG_ADDR_W-1:0] idRd,
    input  logic                  idRegWrite,
    input  logic                  idMemRead,
    input  logic [1:0]            idSrc2Sel,
    input  logic                  holdIn,
    input  logic                  branchFlush,
    output logic [1:0]            input2Select,
    output logic [1:0]            fwdASelect,
    output logic [1:0]            fwdBSelect,
    output logic                  stallDecode,
    output logic                  exBubble,
    output logic [CNT_W-1:0]      stallCount
);

    // In-flight destination records, index 0 = EX, 1 = MEM, 2 = WB.
    stage_rec_t       stage_reg [NUM_STAGES];
    ctrl_state_t      state_reg;
    src2_sel_t        input2_sel_reg;
    fwd_sel_t         fwd_a_reg;
    fwd_sel_t         fwd_b_reg;
    logic             ex_bubble_reg;
    logic [CNT_W-1:0] stall_cnt_reg;

    // Decode-time decisions.
    logic [NUM_FWD_STAGES-1:0] rs1_hit;
    logic [NUM_FWD_STAGES-1:0] rs2_hit;
    logic                      src2_is_reg;
    logic                      load_use;
    logic                      stall_take;
    logic                      issue;
    stage_rec_t                ex_next;
    src2_sel_t                 input2_sel_next;
    fwd_sel_t                  fwd_a_next;
    fwd_sel_t                  fwd_b_next;
    logic [CNT_W-1:0]          stall_cnt_next;

    // One comparator per (source, producer stage) pair.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_FWD_STAGES; gi++) begin : g_fwd_cmp
            fwd_compare #(
                .REG_ADDR_W(REG_ADDR_W)
            ) u_cmp_rs1 (
                .rs           (idRs1),
                .rec_valid    (stage_reg[gi].valid),
                .rec_rd       (stage_reg[gi].rd),
                .rec_reg_write(stage_reg[gi].regWrite),
                .hit          (rs1_hit[gi])
            );

            fwd_compare #(
                .REG_ADDR_W(REG_ADDR_W)
            ) u_cmp_rs2 (
                .rs           (idRs2),
                .rec_valid    (stage_reg[gi].valid),
                .rec_rd       (stage_reg[gi].rd),
                .rec_reg_write(stage_reg[gi].regWrite),
                .hit          (rs2_hit[gi])
            );
        end
    endgenerate

    // Hazard detection and the values that will be loaded into EX.
    always_comb begin
        src2_is_reg = (idSrc2Sel == SRC2_REG);

        // A load in EX cannot forward yet; the consumer must wait one cycle.
        // rs2 only counts when the ALU actually reads the register operand.
        // In STALL the EX slot is a bubble, so a second hazard cannot arise.
        load_use = idValid
                && (state_reg == RUN)
                && stage_reg[EX_IDX].valid
                && stage_reg[EX_IDX].memRead
                && (stage_reg[EX_IDX].rd != '0)
                && ((stage_reg[EX_IDX].rd == RD_W'(idRs1))
                    || (src2_is_reg && (stage_reg[EX_IDX].rd == RD_W'(idRs2))));

        // A flush discards the consumer, so there is nothing to stall for.
        stall_take  = load_use && !branchFlush;
        stallDecode = stall_take && !holdIn && !reset;

        // The ID instruction enters EX only when it is real and neither
        // stalled nor flushed; otherwise EX receives a bubble.
        issue = idValid && !branchFlush && !load_use;

        ex_next         = BUBBLE_REC;
        input2_sel_next = SRC2_REG;
        fwd_a_next      = FWD_RF;
        fwd_b_next      = FWD_RF;
        if (issue) begin
            ex_next.valid    = 1'b1;
            ex_next.rd       = RD_W'(idRd);
            ex_next.regWrite = idRegWrite;
            ex_next.memRead  = idMemRead;
            input2_sel_next  = legal_src2(idSrc2Sel);
            fwd_a_next       = pick_fwd(rs1_hit[EX_IDX], rs1_hit[MEM_IDX]);
            if (src2_is_reg) begin
                fwd_b_next = pick_fwd(rs2_hit[EX_IDX], rs2_hit[MEM_IDX]);
            end
        end

        // Saturating stall counter increment.
        stall_cnt_next = stall_cnt_reg;
        if (stall_take && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_next = stall_cnt_reg + CNT_W'(1);
        end
    end

    // Stall FSM, stage records and registered selects; hold freezes all of it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                stage_reg[i] <= BUBBLE_REC;
            end
            state_reg      <= RUN;
            input2_sel_reg <= SRC2_REG;
            fwd_a_reg      <= FWD_RF;
            fwd_b_reg      <= FWD_RF;
            ex_bubble_reg  <= 1'b1;
            stall_cnt_reg  <= '0;
        end else if (!holdIn) begin
            for (int i = NUM_STAGES - 1; i > 0; i--) begin
                stage_reg[i] <= stage_reg[i-1];
            end
            stage_reg[EX_IDX] <= ex_next;
            input2_sel_reg    <= input2_sel_next;
            fwd_a_reg         <= fwd_a_next;
            fwd_b_reg         <= fwd_b_next;
            ex_bubble_reg     <= !issue;
            stall_cnt_reg     <= stall_cnt_next;
            case (state_reg)
                RUN:     state_reg <= stall_take ? STALL : RUN;
                STALL:   state_reg <= RUN;
                default: state_reg <= RUN;
            endcase
        end
    end

    assign input2Select = input2_sel_reg;
    assign fwdASelect   = fwd_a_reg;
    assign fwdBSelect   = fwd_b_reg;
    assign exBubble     = ex_bubble_reg;
    assign stallCount   = stall_cnt_reg;

endmodule
